// File: rtl/toe_axi_device_adapter.sv
// AXI4-Lite slave to simple req/gnt/rvalid device bus bridge.
// One transaction in flight; AW/W/AR are latched independently and arbitrated in IDLE.
package axi_pkg;
  localparam int AxiAddrWidth = 32;
  localparam int AxiDataWidth = 32;

  typedef struct packed {
    logic                      aw_valid;
    logic [AxiAddrWidth-1:0]   aw_addr;
    logic                      w_valid;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic                      b_ready;
    logic                      ar_valid;
    logic [AxiAddrWidth-1:0]   ar_addr;
    logic                      r_ready;
  } axi_h2d_t;

  typedef struct packed {
    logic                    aw_ready;
    logic                    w_ready;
    logic                    b_valid;
    logic [1:0]              b_resp;
    logic                    ar_ready;
    logic                    r_valid;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
  } axi_d2h_t;
endpackage

module toe_axi_device_adapter #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  axi_pkg::axi_h2d_t         axi_i,
  output axi_pkg::axi_d2h_t         axi_o,
  output logic                      req_o,
  input  logic                      gnt_i,
  output logic                      we_o,
  output logic [DataWidth/8-1:0]    be_o,
  output logic [AddressWidth-1:0]   addr_o,
  output logic [DataWidth-1:0]      wdata_o,
  input  logic                      rvalid_i,
  input  logic [DataWidth-1:0]      rdata_i,
  input  logic                      err_i
);
  localparam int StrbWidth  = DataWidth / 8;
  localparam int TimerWidth = $clog2(TimeoutCycles + 1);
  localparam int AxiDw      = axi_pkg::AxiDataWidth;
  localparam logic [AddressWidth-1:0] AddrMask = ~(AddressWidth'(3));

  typedef enum logic [2:0] {IDLE, REQ, WAIT, BRESP, RRESP} state_t;

  state_t                  state_reg, state_next;
  logic                    aw_held_reg, aw_held_next, w_held_reg, w_held_next;
  logic                    ar_held_reg, ar_held_next, last_read_reg, last_read_next;
  logic                    is_read_reg, is_read_next;
  logic [AddressWidth-1:0] aw_addr_reg, aw_addr_next, ar_addr_reg, ar_addr_next;
  logic [DataWidth-1:0]    w_data_reg, w_data_next;
  logic [StrbWidth-1:0]    w_strb_reg, w_strb_next;
  logic [TimerWidth-1:0]   timer_reg, timer_next;
  logic                    aw_ready_reg, aw_ready_next, w_ready_reg, w_ready_next;
  logic                    ar_ready_reg, ar_ready_next;
  logic                    b_valid_reg, b_valid_next, r_valid_reg, r_valid_next;
  logic [1:0]              b_resp_reg, b_resp_next, r_resp_reg, r_resp_next;
  logic [DataWidth-1:0]    r_data_reg, r_data_next;
  logic                    req_reg, req_next, we_reg, we_next;
  logic [StrbWidth-1:0]    be_reg, be_next;
  logic [AddressWidth-1:0] addr_reg, addr_next;
  logic [DataWidth-1:0]    wdata_reg, wdata_next;
  logic                    wr_pending, rd_pending, timed_out;

  assign timed_out = (32'(timer_reg) + 32'd1) == 32'(TimeoutCycles);

  always_comb begin
    state_next     = state_reg;
    aw_held_next   = aw_held_reg;
    w_held_next    = w_held_reg;
    ar_held_next   = ar_held_reg;
    last_read_next = last_read_reg;
    is_read_next   = is_read_reg;
    aw_addr_next   = aw_addr_reg;
    ar_addr_next   = ar_addr_reg;
    w_data_next    = w_data_reg;
    w_strb_next    = w_strb_reg;
    timer_next     = timer_reg;
    b_valid_next   = b_valid_reg;
    b_resp_next    = b_resp_reg;
    r_valid_next   = r_valid_reg;
    r_resp_next    = r_resp_reg;
    r_data_next    = r_data_reg;
    req_next       = req_reg;
    we_next        = we_reg;
    be_next        = be_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wr_pending     = 1'b0;
    rd_pending     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (axi_i.aw_valid && aw_ready_reg) begin
          aw_held_next = 1'b1;
          aw_addr_next = AddressWidth'(axi_i.aw_addr);
        end
        if (axi_i.w_valid && w_ready_reg) begin
          w_held_next = 1'b1;
          w_data_next = DataWidth'(axi_i.w_data);
          w_strb_next = StrbWidth'(axi_i.w_strb);
        end
        if (axi_i.ar_valid && ar_ready_reg) begin
          ar_held_next = 1'b1;
          ar_addr_next = AddressWidth'(axi_i.ar_addr);
        end
        wr_pending = aw_held_next && w_held_next;
        rd_pending = ar_held_next;
        // The last-served flag only moves on contention, so back-to-back collisions alternate.
        if (rd_pending && (!wr_pending || !last_read_reg)) begin
          state_next   = REQ;
          is_read_next = 1'b1;
          req_next     = 1'b1;
          we_next      = 1'b0;
          be_next      = '1;
          addr_next    = ar_addr_next & AddrMask;
          wdata_next   = '0;
          if (wr_pending) last_read_next = 1'b1;
        end else if (wr_pending) begin
          state_next   = REQ;
          is_read_next = 1'b0;
          req_next     = 1'b1;
          we_next      = 1'b1;
          be_next      = w_strb_next;
          addr_next    = aw_addr_next & AddrMask;
          wdata_next   = w_data_next;
          if (rd_pending) last_read_next = 1'b0;
        end
      end
      REQ: begin
        if (gnt_i) begin
          state_next = WAIT;
          req_next   = 1'b0;
          timer_next = '0;
        end
      end
      WAIT: begin
        timer_next = timer_reg + TimerWidth'(1);
        if (rvalid_i || timed_out) begin
          if (is_read_reg) begin
            state_next   = RRESP;
            r_valid_next = 1'b1;
            r_resp_next  = (rvalid_i && !err_i) ? 2'b00 : 2'b10;
            r_data_next  = rvalid_i ? rdata_i : '0;
          end else begin
            state_next   = BRESP;
            b_valid_next = 1'b1;
            b_resp_next  = (rvalid_i && !err_i) ? 2'b00 : 2'b10;
          end
        end
      end
      BRESP: begin
        if (axi_i.b_ready) begin
          state_next   = IDLE;
          b_valid_next = 1'b0;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
        end
      end
      RRESP: begin
        if (axi_i.r_ready) begin
          state_next   = IDLE;
          r_valid_next = 1'b0;
          ar_held_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    aw_ready_next = (state_next == IDLE) && !aw_held_next;
    w_ready_next  = (state_next == IDLE) && !w_held_next;
    ar_ready_next = (state_next == IDLE) && !aw_held_next && !w_held_next && !ar_held_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      aw_held_reg   <= 1'b0;
      w_held_reg    <= 1'b0;
      ar_held_reg   <= 1'b0;
      last_read_reg <= 1'b0;
      is_read_reg   <= 1'b0;
      aw_addr_reg   <= '0;
      ar_addr_reg   <= '0;
      w_data_reg    <= '0;
      w_strb_reg    <= '0;
      timer_reg     <= '0;
      aw_ready_reg  <= 1'b0;
      w_ready_reg   <= 1'b0;
      ar_ready_reg  <= 1'b0;
      b_valid_reg   <= 1'b0;
      b_resp_reg    <= 2'b00;
      r_valid_reg   <= 1'b0;
      r_resp_reg    <= 2'b00;
      r_data_reg    <= '0;
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      be_reg        <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      aw_held_reg   <= aw_held_next;
      w_held_reg    <= w_held_next;
      ar_held_reg   <= ar_held_next;
      last_read_reg <= last_read_next;
      is_read_reg   <= is_read_next;
      aw_addr_reg   <= aw_addr_next;
      ar_addr_reg   <= ar_addr_next;
      w_data_reg    <= w_data_next;
      w_strb_reg    <= w_strb_next;
      timer_reg     <= timer_next;
      aw_ready_reg  <= aw_ready_next;
      w_ready_reg   <= w_ready_next;
      ar_ready_reg  <= ar_ready_next;
      b_valid_reg   <= b_valid_next;
      b_resp_reg    <= b_resp_next;
      r_valid_reg   <= r_valid_next;
      r_resp_reg    <= r_resp_next;
      r_data_reg    <= r_data_next;
      req_reg       <= req_next;
      we_reg        <= we_next;
      be_reg        <= be_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
    end
  end

  always_comb begin
    axi_o          = '0;
    axi_o.aw_ready = aw_ready_reg;
    axi_o.w_ready  = w_ready_reg;
    axi_o.b_valid  = b_valid_reg;
    axi_o.b_resp   = b_resp_reg;
    axi_o.ar_ready = ar_ready_reg;
    axi_o.r_valid  = r_valid_reg;
    axi_o.r_data   = AxiDw'(r_data_reg);
    axi_o.r_resp   = r_resp_reg;
  end

  assign req_o   = req_reg;
  assign we_o    = we_reg;
  assign be_o    = be_reg;
  assign addr_o  = addr_reg;
  assign wdata_o = wdata_reg;
endmodule

// File: tb/tb_toe_axi_device_adapter.sv
// Directed bench for toe_axi_device_adapter: a device model driven step by step,
// with expected AXI responses queued at issue time and checked when B/R appear.
module tb_toe_axi_device_adapter;
  logic              clk_i = 1'b0;
  logic              rst_i;
  axi_pkg::axi_h2d_t axi_i;
  axi_pkg::axi_d2h_t axi_o;
  logic              req_o, gnt_i, we_o, rvalid_i, err_i;
  logic [3:0]        be_o;
  logic [31:0]       addr_o, wdata_o, rdata_i;

  typedef struct {
    bit          is_read;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  toe_axi_device_adapter #(
    .DataWidth(32), .AddressWidth(32), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .axi_i(axi_i), .axi_o(axi_o),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_axi_o"}, 64'(axi_o), 64'd0);
    check({tag, "_req"}, 64'(req_o), 64'd0);
    check({tag, "_we"}, 64'(we_o), 64'd0);
    check({tag, "_be"}, 64'(be_o), 64'd0);
    check({tag, "_addr"}, 64'(addr_o), 64'd0);
    check({tag, "_wdata"}, 64'(wdata_o), 64'd0);
  endtask

  task automatic push(input bit is_read, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    e.is_read = is_read;
    e.resp    = resp;
    e.data    = data;
    sb.push_back(e);
  endtask

  task automatic do_ar(input logic [31:0] addr);
    int n = 0;
    axi_i.ar_valid = 1'b1;
    axi_i.ar_addr  = addr;
    while (axi_o.ar_ready !== 1'b1 && n < 50) begin step(); n++; end
    check("ar_ready_seen", 64'(axi_o.ar_ready), 64'd1);
    step();
    axi_i.ar_valid = 1'b0;
  endtask

  // Device side: wait for req, check the request, grant at once, respond after rsp_delay cycles.
  task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input int rsp_delay, input logic [31:0] rdata, input logic err);
    int n = 0;
    while (req_o !== 1'b1 && n < 50) begin step(); n++; end
    check({tag, "_req"}, 64'(req_o), 64'd1);
    check({tag, "_we"}, 64'(we_o), 64'(exp_we));
    check({tag, "_addr"}, 64'(addr_o), 64'(exp_addr));
    check({tag, "_be"}, 64'(be_o), 64'(exp_be));
    check({tag, "_wdata"}, 64'(wdata_o), 64'(exp_wdata));
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    check({tag, "_req_drop"}, 64'(req_o), 64'd0);
    repeat (rsp_delay) step();
    rvalid_i = 1'b1;
    rdata_i  = rdata;
    err_i    = err;
    step();
    rvalid_i = 1'b0;
    rdata_i  = '0;
    err_i    = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   n = 0;
    while (axi_o.b_valid !== 1'b1 && axi_o.r_valid !== 1'b1 && n < 50) begin step(); n++; end
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.is_read = 1'b0; e.resp = 2'bxx; e.data = 'x; end
    check({tag, "_r_valid"}, 64'(axi_o.r_valid), 64'(e.is_read));
    check({tag, "_b_valid"}, 64'(axi_o.b_valid), 64'(!e.is_read));
    if (e.is_read) begin
      check({tag, "_r_resp"}, 64'(axi_o.r_resp), 64'(e.resp));
      check({tag, "_r_data"}, 64'(axi_o.r_data), 64'(e.data));
    end else begin
      check({tag, "_b_resp"}, 64'(axi_o.b_resp), 64'(e.resp));
    end
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 64'(e.is_read ? axi_o.r_valid : axi_o.b_valid), 64'd1);
      check({tag, "_hold_resp"}, 64'(e.is_read ? axi_o.r_resp : axi_o.b_resp), 64'(e.resp));
    end
    axi_i.b_ready = 1'b1;
    axi_i.r_ready = 1'b1;
    step();
    axi_i.b_ready = 1'b0;
    axi_i.r_ready = 1'b0;
    check({tag, "_valid_clear"}, 64'({axi_o.b_valid, axi_o.r_valid}), 64'd0);
    $display("txn %s: %s resp=%b data=0x%08h", tag, e.is_read ? "read" : "write", e.resp, e.data);
  endtask

  initial begin
    int cnt;
    axi_i    = '0;
    rst_i    = 1'b1;
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    err_i    = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_i = 1'b0;
    step();
    check("idle_readies", 64'({axi_o.aw_ready, axi_o.w_ready, axi_o.ar_ready}), 64'b111);

    // Read with immediate grant and response: r_valid three cycles after the AR handshake.
    do_ar(32'h0004_0004);
    check("rd_lat_req", 64'(req_o), 64'd1);
    push(1'b1, 2'b00, 32'hDEAD_BEEF);
    serve("rd_lat", 1'b0, 32'h0004_0004, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    check("rd_lat_rvalid", 64'(axi_o.r_valid), 64'd1);
    collect("rd_lat", 0);

    // W arrives two cycles before an unaligned AW.
    axi_i.w_valid = 1'b1;
    axi_i.w_data  = 32'h1234_5678;
    axi_i.w_strb  = 4'b0011;
    step();
    axi_i.w_valid = 1'b0;
    check("w_held_readies", 64'({axi_o.aw_ready, axi_o.w_ready, axi_o.ar_ready}), 64'b100);
    step();
    axi_i.aw_valid = 1'b1;
    axi_i.aw_addr  = 32'h0004_0006;
    step();
    axi_i.aw_valid = 1'b0;
    push(1'b0, 2'b00, 32'h0);
    serve("wr_split", 1'b1, 32'h0004_0004, 4'b0011, 32'h1234_5678, 2, 32'h0, 1'b0);
    collect("wr_split", 0);

    // Collision right after reset: read first; the repeat collision serves the write first.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] wa, wd, ra, rd;
      wa = (k == 0) ? 32'h100 : 32'h300;
      wd = (k == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
      ra = (k == 0) ? 32'h200 : 32'h400;
      rd = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
      axi_i.aw_valid = 1'b1; axi_i.aw_addr = wa;
      axi_i.w_valid  = 1'b1; axi_i.w_data = wd; axi_i.w_strb = 4'hF;
      axi_i.ar_valid = 1'b1; axi_i.ar_addr = ra;
      step();
      axi_i.aw_valid = 1'b0; axi_i.w_valid = 1'b0; axi_i.ar_valid = 1'b0;
      if (k == 0) begin
        push(1'b1, 2'b00, rd);
        push(1'b0, 2'b00, 32'h0);
        serve("coll_rd", 1'b0, ra, 4'hF, 32'h0, 0, rd, 1'b0);
        collect("coll_rd", 0);
        serve("coll_wr", 1'b1, wa, 4'hF, wd, 0, 32'h0, 1'b0);
        collect("coll_wr", 0);
      end else begin
        push(1'b0, 2'b00, 32'h0);
        push(1'b1, 2'b00, rd);
        serve("coll2_wr", 1'b1, wa, 4'hF, wd, 1, 32'h0, 1'b0);
        collect("coll2_wr", 0);
        serve("coll2_rd", 1'b0, ra, 4'hF, 32'h0, 1, rd, 1'b0);
        collect("coll2_rd", 0);
      end
    end

    // Read with no device response: timeout after 8 WAIT cycles, late rvalid ignored.
    do_ar(32'h500);
    push(1'b1, 2'b10, 32'h0);
    check("to_req", 64'(req_o), 64'd1);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    cnt = 0;
    while (axi_o.r_valid !== 1'b1 && cnt < 20) begin step(); cnt++; end
    check("to_cycles", 64'(cnt), 64'd8);
    rvalid_i = 1'b1;
    rdata_i  = 32'h0000_0BAD;
    step();
    rvalid_i = 1'b0;
    rdata_i  = '0;
    check("to_late_rdata", 64'(axi_o.r_data), 64'd0);
    collect("timeout", 0);
    rvalid_i = 1'b1;
    step();
    rvalid_i = 1'b0;
    step();
    check("idle_rvalid_ignored", 64'({axi_o.b_valid, axi_o.r_valid, req_o}), 64'd0);

    // Write with device error and b_ready held low for 5 cycles.
    axi_i.aw_valid = 1'b1; axi_i.aw_addr = 32'h600;
    axi_i.w_valid  = 1'b1; axi_i.w_data = 32'hCAFE_F00D; axi_i.w_strb = 4'hC;
    step();
    axi_i.aw_valid = 1'b0; axi_i.w_valid = 1'b0;
    push(1'b0, 2'b10, 32'h0);
    serve("wr_err", 1'b1, 32'h600, 4'hC, 32'hCAFE_F00D, 0, 32'h0, 1'b1);
    collect("wr_err", 5);

    // Reset while waiting for the device; stale rvalid afterwards must not produce R.
    do_ar(32'h700);
    check("rst_wait_req", 64'(req_o), 64'd1);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_all_zero("rst_wait");
    rvalid_i = 1'b1;
    rdata_i  = 32'h7777_7777;
    step();
    rvalid_i = 1'b0;
    rdata_i  = '0;
    step();
    check("rst_stale_resp", 64'({axi_o.b_valid, axi_o.r_valid, req_o}), 64'd0);
    do_ar(32'h800);
    push(1'b1, 2'b00, 32'h3333_3333);
    serve("post_rst", 1'b0, 32'h800, 4'hF, 32'h0, 0, 32'h3333_3333, 1'b0);
    collect("post_rst", 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
